// File: rtl/i2c_request_arbiter.sv
// ============================================================================
// Module   : i2c_request_arbiter
// Purpose  : Round-robin sharing of one I2C master between two requesters,
//            with launch pulse, watchdog timeout and status/read-data return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_request_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       ClockLocked,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [6:0] Addr0,
  input  logic [6:0] Addr1,
  input  logic [7:0] Data0,
  input  logic [7:0] Data1,
  input  logic       RW0,
  input  logic       RW1,
  output logic       Grant0,
  output logic       Grant1,
  output logic       Done0,
  output logic       Done1,
  output logic       Error0,
  output logic       Error1,
  output logic [7:0] RdData,
  output logic       Busy,
  output logic       MasterGo,
  output logic [6:0] MasterAddr,
  output logic [7:0] MasterData,
  output logic       MasterRW,
  input  logic       MasterDone,
  input  logic       MasterAckError,
  input  logic [7:0] MasterRdData
);

  localparam int                c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_load   = 3'd1;
  localparam logic [2:0] c_st_go     = 3'd2;
  localparam logic [2:0] c_st_wait   = 3'd3;
  localparam logic [2:0] c_st_finish = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [7:0]         rd_q, rd_d;
  logic [6:0]         maddr_q, maddr_d;
  logic [7:0]         mdata_q, mdata_d;
  logic               mrw_q, mrw_d;
  logic [c_cnt_w-1:0] cnt_inc;
  logic               granted;

  assign cnt_inc = cnt_q + c_cnt_one;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mrw_d   = mrw_q;
    case (state_q)
      c_st_idle: begin
        if (ClockLocked && (Req0 || Req1)) begin
          // On a tie the requester that was not served last wins.
          win_d   = (Req0 && Req1) ? ~last_q : Req1;
          state_d = c_st_load;
        end
      end
      c_st_load: begin
        maddr_d = win_q ? Addr1 : Addr0;
        mdata_d = win_q ? Data1 : Data0;
        mrw_d   = win_q ? RW1   : RW0;
        state_d = c_st_go;
      end
      c_st_go: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = c_st_wait;
      end
      c_st_wait: begin
        cnt_d = cnt_inc;
        // A completion on the same cycle as expiry takes priority.
        if (MasterDone) begin
          err_d = MasterAckError;
          if (mrw_q) begin
            rd_d = MasterRdData;
          end
          state_d = c_st_finish;
        end else if (cnt_inc == c_timeout) begin
          err_d   = 1'b1;
          state_d = c_st_finish;
        end
      end
      c_st_finish: begin
        last_d  = win_q;
        state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= c_st_idle;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 8'h00;
      maddr_q <= 7'h00;
      mdata_q <= 8'h00;
      mrw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mrw_q   <= mrw_d;
    end
  end

  assign granted = (state_q == c_st_load) || (state_q == c_st_go) ||
                   (state_q == c_st_wait) || (state_q == c_st_finish);

  assign Grant0     = granted & ~win_q;
  assign Grant1     = granted &  win_q;
  assign Done0      = (state_q == c_st_finish) & ~win_q;
  assign Done1      = (state_q == c_st_finish) &  win_q;
  assign Error0     = Done0 & err_q;
  assign Error1     = Done1 & err_q;
  assign RdData     = rd_q;
  assign Busy       = (state_q != c_st_idle);
  assign MasterGo   = (state_q == c_st_go);
  assign MasterAddr = maddr_q;
  assign MasterData = mdata_q;
  assign MasterRW   = mrw_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_request_arbiter.sv
// ============================================================================
// Module   : tb_i2c_request_arbiter
// Purpose  : Scoreboard bench for i2c_request_arbiter (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_request_arbiter;

  logic       clock = 1'b0;
  logic       Reset;
  logic       ClockLocked;
  logic       Req0, Req1;
  logic [6:0] Addr0, Addr1;
  logic [7:0] Data0, Data1;
  logic       RW0, RW1;
  logic       Grant0, Grant1, Done0, Done1, Error0, Error1;
  logic [7:0] RdData;
  logic       Busy, MasterGo;
  logic [6:0] MasterAddr;
  logic [7:0] MasterData;
  logic       MasterRW;
  logic       MasterDone, MasterAckError;
  logic [7:0] MasterRdData;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;
  logic [7:0] exp_rd = 8'h00;

  typedef struct {
    int         port;
    bit         err;
    logic [6:0] addr;
    logic [7:0] data;
    bit         rw;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];

  i2c_request_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clock(clock), .Reset(Reset), .ClockLocked(ClockLocked),
    .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
    .Data0(Data0), .Data1(Data1), .RW0(RW0), .RW1(RW1),
    .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1),
    .Error0(Error0), .Error1(Error1), .RdData(RdData), .Busy(Busy),
    .MasterGo(MasterGo), .MasterAddr(MasterAddr), .MasterData(MasterData),
    .MasterRW(MasterRW), .MasterDone(MasterDone),
    .MasterAckError(MasterAckError), .MasterRdData(MasterRdData)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int port, input bit err, input logic [6:0] addr,
                          input logic [7:0] data, input bit rw, input logic [7:0] rd);
    exp_t e;
    e.port = port; e.err = err; e.addr = addr; e.data = data; e.rw = rw; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // drop: 0 keep requests, 1 drop own request, 2 drop both (applied in FINISH)
  task automatic serve(input int port, input int delay, input bit ack,
                       input logic [7:0] rd, input bit timeout, input int drop);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!MasterGo && n < 100);
    if (!MasterGo) begin
      check("go_wait_expired", 0, 1);
      return;
    end
    check("grant_at_go", {Grant1, Grant0}, (port == 1) ? 2'b10 : 2'b01);
    if (!timeout) begin
      repeat (delay) @(posedge clock);
      #1 MasterDone = 1'b1; MasterAckError = ack; MasterRdData = rd;
      @(posedge clock);
      #1 MasterDone = 1'b0; MasterAckError = 1'b0; MasterRdData = 8'h00;
    end
    n = 0;
    do begin @(negedge clock); n++; end while (!(Done0 || Done1) && n < 200);
    if (!(Done0 || Done1)) check("done_wait_expired", 0, 1);
    if (timeout) check("timeout_latency", 64'(n), 64'd16);
    if (drop == 1) begin
      if (port == 1) Req1 = 1'b0; else Req0 = 1'b0;
    end else if (drop == 2) begin
      Req0 = 1'b0; Req1 = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 Reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 Reset = 1'b0;
    exp_rd = 8'h00;
  endtask

  // Monitor: pops the scoreboard on every Done pulse
  initial begin : monitor
    exp_t e;
    logic [1:0] oh;
    forever begin
      @(negedge clock);
      if (Reset) begin
        go_cnt = 0;
      end else begin
        if (MasterGo) go_cnt++;
        if (Done0 || Done1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {Done1, Done0}, 2'b00);
          end else begin
            e  = exp_q.pop_front();
            oh = (e.port == 1) ? 2'b10 : 2'b01;
            check("done_port", {Done1, Done0}, oh);
            check("error", {Error1, Error0}, e.err ? oh : 2'b00);
            check("rd_data", RdData, e.rd);
            check("master_addr", MasterAddr, e.addr);
            check("master_data", MasterData, e.data);
            check("master_rw", MasterRW, e.rw);
            check("grant_at_done", {Grant1, Grant0}, oh);
            check("go_count", 64'(go_cnt), 64'd1);
            go_cnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int bad;
    Reset = 1'b1; ClockLocked = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0; RW0 = 1'b0; RW1 = 1'b0;
    MasterDone = 1'b0; MasterAckError = 1'b0; MasterRdData = 8'h00;
    repeat (3) @(posedge clock);
    #1 Reset = 1'b0;
    @(negedge clock);
    check("reset_state", {Grant0, Grant1, Done0, Done1, Error0, Error1, Busy, MasterGo,
                          MasterAddr, MasterData, MasterRW, RdData}, 64'd0);

    // Single write on port 0
    Addr0 = 7'h48; Data0 = 8'hA5; RW0 = 1'b0;
    push_exp(0, 0, 7'h48, 8'hA5, 0, exp_rd);
    Req0 = 1'b1;
    serve(0, 5, 0, 8'h00, 0, 1);

    // Simultaneous requests from a fresh reset: order 0,1,0,1
    pulse_reset();
    Addr0 = 7'h10; Data0 = 8'h11; Addr1 = 7'h20; Data1 = 8'h22;
    push_exp(0, 0, 7'h10, 8'h11, 0, exp_rd);
    push_exp(1, 0, 7'h20, 8'h22, 0, exp_rd);
    push_exp(0, 0, 7'h10, 8'h11, 0, exp_rd);
    push_exp(1, 0, 7'h20, 8'h22, 0, exp_rd);
    Req0 = 1'b1; Req1 = 1'b1;
    serve(0, 1, 0, 8'h00, 0, 0);
    serve(1, 2, 0, 8'h00, 0, 0);
    serve(0, 1, 0, 8'h00, 0, 0);
    serve(1, 3, 0, 8'h00, 0, 2);

    // Timeout on port 0 while port 1 waits
    Addr0 = 7'h33; Data0 = 8'h44; Addr1 = 7'h2A; Data1 = 8'h5B;
    push_exp(0, 1, 7'h33, 8'h44, 0, exp_rd);
    push_exp(1, 0, 7'h2A, 8'h5B, 0, exp_rd);
    Req0 = 1'b1;
    @(posedge clock);
    #1 Req1 = 1'b1;
    serve(0, 0, 0, 8'h00, 1, 1);
    serve(1, 2, 0, 8'h00, 0, 1);

    // Read with NACK on port 1
    Addr1 = 7'h55; Data1 = 8'h66; RW1 = 1'b1;
    exp_rd = 8'h3C;
    push_exp(1, 1, 7'h55, 8'h66, 1, exp_rd);
    Req1 = 1'b1;
    serve(1, 3, 1, 8'h3C, 0, 1);
    RW1 = 1'b0;

    // A write must not disturb the previously read byte
    Addr0 = 7'h12; Data0 = 8'h34; RW0 = 1'b0;
    push_exp(0, 0, 7'h12, 8'h34, 0, exp_rd);
    Req0 = 1'b1;
    serve(0, 1, 0, 8'hFF, 0, 1);

    // ClockLocked gating
    ClockLocked = 1'b0;
    Addr0 = 7'h61; Data0 = 8'h62;
    Req0 = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (Grant0 || Grant1 || MasterGo || Busy) bad++;
    end
    check("lock_gate", 64'(bad), 64'd0);
    ClockLocked = 1'b1;
    @(negedge clock);
    check("grant_after_lock", {Grant1, Grant0}, 2'b01);
    push_exp(0, 0, 7'h61, 8'h62, 0, exp_rd);
    serve(0, 1, 0, 8'h00, 0, 1);

    // Async reset during WAIT on port 1 (last served is 0 here)
    Addr1 = 7'h70; Data1 = 8'h71;
    Req1 = 1'b1;
    bad = 0;
    do begin @(negedge clock); bad++; end while (!MasterGo && bad < 100);
    check("reset_test_go", MasterGo, 1'b1);
    repeat (2) @(posedge clock);
    #2 Reset = 1'b1;
    #1;
    check("reset_outputs", {Grant0, Grant1, Done0, Done1, Error0, Error1, Busy, MasterGo,
                            MasterAddr, MasterData, MasterRW, RdData}, 64'd0);
    exp_rd = 8'h00;
    Req0 = 1'b1; Addr0 = 7'h05; Data0 = 8'h06;
    @(posedge clock);
    #1 Reset = 1'b0;
    push_exp(0, 0, 7'h05, 8'h06, 0, exp_rd);
    push_exp(1, 0, 7'h70, 8'h71, 0, exp_rd);
    serve(0, 1, 0, 8'h00, 0, 0);
    serve(1, 1, 0, 8'h00, 0, 2);

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_request_arbiter.md
# i2c_request_arbiter

Shares the single I2C master (Go/SCL/SDA control unit) between two requesters. The block arbitrates round-robin, latches the winner's address, data and R/W into registers that drive the master, and pulses the master's Go. It then waits for the master's completion, guarded by a watchdog, and returns status and read data to the granted requester. It sits between the lab-level command sources and the I2C control unit, and all master launches go through it.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: number of WAIT cycles without MasterDone before the transaction is aborted with an error. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clock, input, 1: single system clock. All logic is rising-edge.
- Reset, input, 1: asynchronous, active-high reset.
- ClockLocked, input, 1: no new grant is issued while low.
- Req0, Req1, input, 1 each: level request. Held high until the matching Done pulse.
- Addr0, Addr1, input, 7 each: slave address of each requester.
- Data0, Data1, input, 8 each: write data of each requester.
- RW0, RW1, input, 1 each: 1 = read, 0 = write.
- Grant0, Grant1, output, 1 each: one-hot. High from LOAD through FINISH for the served requester.
- Done0, Done1, output, 1 each: one-cycle completion pulse.
- Error0, Error1, output, 1 each: high only coincident with the matching Done, on NACK or timeout.
- RdData, output, 8: read byte. Valid while a Done is high and held until the next FINISH.
- Busy, output, 1: high in every state except IDLE.
- MasterGo, output, 1: one-cycle launch pulse to the I2C master.
- MasterAddr, output, 7; MasterData, output, 8; MasterRW, output, 1: registered. Stable from LOAD until the next LOAD.
- MasterDone, input, 1: one-cycle completion pulse from the master.
- MasterAckError, input, 1: sampled on the same cycle as MasterDone.
- MasterRdData, input, 8: sampled on the same cycle as MasterDone.

## Operation
- FSM states: IDLE, LOAD, GO, WAIT, FINISH. Encoding is 3 bits; unused codes return to IDLE.
- IDLE:
  - When ClockLocked=1 and (Req0 or Req1), select a winner and go to LOAD.
  - Round-robin: if both requests are high, the winner is the requester not served last. If only one request is high, it wins.
  - The LastServed pointer resets to 1, so Req0 wins the first tie.
- LOAD:
  - Grant of the winner goes high.
  - Master{Addr,Data,RW} are loaded from the winner's inputs.
  - Next state is GO.
- GO: MasterGo=1 for exactly this cycle; the timeout counter is cleared. Next state is WAIT.
- WAIT:
  - The counter increments each cycle.
  - If MasterDone=1, capture MasterAckError and MasterRdData (the latter only when MasterRW=1; otherwise RdData keeps its old value), then go to FINISH.
  - Else, if the counter equals TIMEOUT_CYCLES, set the error flag and go to FINISH.
- FINISH:
  - DoneN=1 and ErrorN=flag.
  - LastServed is updated to the served requester.
  - Next state is IDLE, and Grant drops at the following edge.
- Requester inputs are sampled only in IDLE and LOAD. Changes to them at any other time are ignored.
- MasterDone and MasterAckError outside WAIT are ignored.
- If Req is still high on the first IDLE cycle after Done, it is treated as a new request.
- If ClockLocked falls mid-transaction, the current transaction completes normally. Only new grants are blocked.

## Timing
- Reset values (applied asynchronously): state=IDLE; Grant*, Done*, Error*, MasterGo, Busy = 0; Master{Addr,Data,RW} = 0; RdData = 0; counter = 0; LastServed = 1.
- Cycle sequence, with Req sampled high in IDLE at edge E0:
  - LOAD after E0: Grant high.
  - GO after E1: MasterGo high, Master registers already valid.
  - WAIT from E2.
- With MasterDone sampled at edge En: FINISH follows, with Done high for one cycle after En. IDLE follows after En+1.
- Minimum request-to-Done latency is 4 edges when MasterDone arrives on the first WAIT cycle.
- Back-to-back service is possible: the next LOAD can start 2 edges after the previous Done.
- If MasterDone and the counter reaching TIMEOUT_CYCLES occur on the same cycle, MasterDone wins and there is no timeout error. AckError is still honoured.
- Reset asserted mid-transaction: outputs clear immediately. No Done is issued for the aborted transaction.

## Test plan
- Single write:
  - Stimulus: Req0 with Addr0=7'h48, Data0=8'hA5, RW0=0; MasterDone 5 cycles after Go, AckError=0.
  - Required: Grant0 high, one MasterGo pulse, MasterAddr=48/MasterData=A5, Done0 pulse with Error0=0, Grant1 never high.
- Simultaneous requests:
  - Stimulus: Req0 and Req1 rise on the same cycle after reset, and both are re-asserted after each Done.
  - Required: service order 0, 1, 0, 1, each with exactly one MasterGo.
- Read with NACK:
  - Stimulus: Req1 with RW1=1; MasterDone with MasterAckError=1 and MasterRdData=8'h3C.
  - Required: Done1 and Error1 pulse together, RdData=3C.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=15, MasterDone never arrives.
  - Required: Done and Error pulse exactly 16 cycles after MasterGo; a pending request on the other port is then granted.
- ClockLocked gating:
  - Stimulus: ClockLocked=0 with Req0 high for 20 cycles, then ClockLocked=1.
  - Required: no Grant or MasterGo during the 20 cycles; Grant0 on the first edge after lock.
- Async reset in WAIT:
  - Stimulus: assert Reset mid-transaction, then release it.
  - Required: all outputs 0 within the same cycle, no Done pulse; after release, a tie between Req0 and Req1 is granted to Req0.
